dbg_str_sink: RTL
=================

DBG_STR_SINK -- requirements
Module: dbg_str_sink

Interface
REQ-001 Parameter P_DATA_ADR, default 6'h14: I/O address of the character data register.
REQ-002 Parameter P_STAT_ADR, default 6'h15: I/O address of the status/control register; SHALL differ from P_DATA_ADR.
REQ-003 Parameter P_DEPTH_LOG2, default 4: FIFO depth is 2**P_DEPTH_LOG2 entries of 8 bits.
REQ-004 cp2  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 ireset  input  1  asynchronous active-low reset.
REQ-006 adr  input  6  AVR I/O address.
REQ-007 dbus_in  input  8  AVR write data.
REQ-008 dbus_out  output  8  AVR read data.
REQ-009 iore  input  1  I/O read strobe.
REQ-010 iowe  input  1  I/O write strobe.
REQ-011 out_en  output  1  read-data drive enable.
REQ-012 str_data  output  8  FIFO head byte to the external consumer.
REQ-013 str_valid  output  1  head byte valid.
REQ-014 str_ready  input  1  consumer accepts head byte.
REQ-015 str_eom  output  1  head byte is the 0x00 end-of-message terminator.

Function
REQ-016 Push: iowe=1 with adr==P_DATA_ADR SHALL write dbus_in into the FIFO tail when the FIFO is not full at that edge.
REQ-017 Full is evaluated on the current entry count only; a push while full SHALL be dropped and SHALL set the sticky ovf flag, even if a pop occurs in the same cycle.
REQ-018 Pop: str_valid=1 and str_ready=1 at a rising edge SHALL remove the head entry.
REQ-019 A simultaneous accepted push and pop SHALL leave the entry count unchanged.
REQ-020 str_valid SHALL equal (entry count != 0); str_data SHALL equal the head entry when valid and 8'h00 when empty.
REQ-021 str_eom SHALL equal str_valid AND (str_data == 8'h00).
REQ-022 Read and write pointers are P_DEPTH_LOG2 bits wide and SHALL wrap modulo depth; the entry count is P_DEPTH_LOG2+1 bits wide.
REQ-023 msg_cnt (4 bits) SHALL track the number of 0x00 bytes held in the FIFO.
  - +1 on an accepted push of 0x00.
  - -1 on a pop of 0x00.
  - Unchanged when both occur in the same cycle.
  - Saturates at 15 and does not go below 0.
REQ-024 Status read value SHALL be {msg_cnt[3:0], 1'b0, ovf, full, empty}.
REQ-025 A data-address read SHALL return the number of free entries, zero-extended to 8 bits; the read SHALL NOT pop.
REQ-026 dbus_out SHALL be combinational from current state: status value when adr==P_STAT_ADR, free count when adr==P_DATA_ADR, 8'h00 otherwise.
REQ-027 out_en SHALL equal iore AND (adr==P_DATA_ADR OR adr==P_STAT_ADR).
REQ-028 A status write with dbus_in[2]=1 SHALL clear ovf; if an overflow occurs in the same cycle, ovf SHALL remain set.
REQ-029 A status write with dbus_in[7]=1 SHALL flush the FIFO (pointers, count and msg_cnt to 0) and take priority over any same-cycle pop; ovf is unaffected unless bit 2 is also set.
REQ-030 Status writes with other bits set SHALL have no effect; writes and reads to any other address SHALL be ignored.

Reset
REQ-031 ireset=0 SHALL immediately clear pointers, count, msg_cnt and ovf, independent of cp2.
REQ-032 During reset: str_valid=0, str_eom=0, str_data=8'h00, and status reads 8'h01.
REQ-033 Reset asserted mid-transfer SHALL discard all buffered bytes; the first push after release SHALL be the head entry.

Verification
REQ-034 Push "Hi\0" (0x48, 0x69, 0x00) with str_ready=0 -> status 8'h10; data-address read returns 13; str_data=0x48, str_valid=1, str_eom=0.
REQ-035 Drain that message with str_ready=1 -> bytes appear in order 0x48, 0x69, 0x00; str_eom=1 only on the third byte; status returns to 8'h01.
REQ-036 Push 17 bytes 0x41 with str_ready=0 -> status 8'h06 (full and ovf); 16 bytes are held; the 17th byte is never output.
REQ-037 With the FIFO full, push and pop in the same cycle -> push dropped, ovf set, count=15; then write 8'h04 to status -> ovf cleared, status 8'h00.
REQ-038 Push 5 bytes, then write 8'h80 to status while str_ready=1 -> next cycle str_valid=0, status 8'h01, no extra pop seen.
REQ-039 Push 3 bytes, then assert ireset for one cycle mid-stream -> str_valid=0 and status 8'h01 immediately; a push of 0x55 afterwards gives str_data=0x55.

Source files
------------

// File: rtl/dbg_str_sink.sv
// dbg_str_sink: AVR I/O-mapped debug string sink.
// The CPU writes characters into a small FIFO through the data register. An
// external consumer drains the FIFO over a valid/ready stream. A 0x00 byte
// marks the end of a message. The status register reports the message count,
// the sticky overflow flag, and the full and empty states.
module dbg_str_sink #(
    parameter logic [5:0]  P_DATA_ADR   = 6'h14,
    parameter logic [5:0]  P_STAT_ADR   = 6'h15,
    parameter int unsigned P_DEPTH_LOG2 = 4
) (
    input  logic       cp2,
    input  logic       ireset,
    input  logic [5:0] adr,
    input  logic [7:0] dbus_in,
    output logic [7:0] dbus_out,
    input  logic       iore,
    input  logic       iowe,
    output logic       out_en,
    output logic [7:0] str_data,
    output logic       str_valid,
    input  logic       str_ready,
    output logic       str_eom
);

    localparam int unsigned DEPTH = 2 ** P_DEPTH_LOG2;

    localparam logic [P_DEPTH_LOG2-1:0] PTR_ONE  = P_DEPTH_LOG2'(1);
    localparam logic [P_DEPTH_LOG2:0]   CNT_ONE  = (P_DEPTH_LOG2 + 1)'(1);
    localparam logic [P_DEPTH_LOG2:0]   CNT_FULL = (P_DEPTH_LOG2 + 1)'(DEPTH);

    // FIFO storage and control state
    logic [7:0]              mem_q [DEPTH];
    logic [P_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [P_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [P_DEPTH_LOG2:0]   count_q,  count_d;
    logic [3:0]              msg_cnt_q, msg_cnt_d;
    logic                    ovf_q,    ovf_d;

    // Decoded strobes
    logic                  full, empty;
    logic                  push_req, push_ok, pop;
    logic                  stat_wr, flush, clr_ovf, ovf_set;
    logic                  zero_in, zero_out;
    logic [7:0]            head;
    logic [7:0]            status;
    logic [P_DEPTH_LOG2:0] free_cnt;

    // Fullness comes only from the registered count. Because of this, a
    // same-cycle pop cannot make room for a push.
    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

    assign push_req = iowe && (adr == P_DATA_ADR);
    assign push_ok  = push_req && !full;
    assign ovf_set  = push_req && full;
    assign pop      = str_valid && str_ready;

    assign stat_wr  = iowe && (adr == P_STAT_ADR);
    assign flush    = stat_wr && dbus_in[7];
    assign clr_ovf  = stat_wr && dbus_in[2];

    assign head     = mem_q[rd_ptr_q];
    assign zero_in  = push_ok && (dbus_in == 8'h00);
    assign zero_out = pop && (head == 8'h00);

    // Stream outputs. The head byte is shown only while the FIFO holds data.
    assign str_valid = !empty;
    assign str_data  = empty ? 8'h00 : head;
    assign str_eom   = str_valid && (str_data == 8'h00);

    assign status   = {msg_cnt_q, 1'b0, ovf_q, full, empty};
    assign free_cnt = CNT_FULL - count_q;

    // Next-state logic for the pointers, the count, the message counter and the overflow flag
    always_comb begin
        // NOTE: every variable is given a default first, so no path leaves one unassigned and no latch is inferred.
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        msg_cnt_d = msg_cnt_q;

        if (flush) begin
            // A flush takes priority over a pop in the same cycle.
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            msg_cnt_d = 4'd0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;

            unique case ({push_ok, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase

            if (zero_in && !zero_out && (msg_cnt_q != 4'd15)) begin
                msg_cnt_d = msg_cnt_q + 4'd1;
            end else if (!zero_in && zero_out && (msg_cnt_q != 4'd0)) begin
                msg_cnt_d = msg_cnt_q - 4'd1;
            end
        end

        // If an overflow happens in the same cycle as a clear, the flag stays set.
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Control state registers, cleared asynchronously by ireset
    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            msg_cnt_q <= 4'd0;
            ovf_q     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            msg_cnt_q <= msg_cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    // FIFO storage write
    always_ff @(posedge cp2) begin
        // NOTE: the storage array has no reset. The count masks stale entries, and str_data is forced to zero while the FIFO is empty.
        if (push_ok) begin
            mem_q[wr_ptr_q] <= dbus_in;
        end
    end

    // CPU read mux and drive enable
    always_comb begin
        dbus_out = 8'h00;
        out_en   = 1'b0;
        if (adr == P_STAT_ADR) begin
            dbus_out = status;
            out_en   = iore;
        end else if (adr == P_DATA_ADR) begin
            dbus_out = 8'(free_cnt);
            out_en   = iore;
        end
    end

endmodule
